// File: rtl/stream_pkg.sv
// stream_pkg: shared StreamBus data type and width
package stream_pkg;
   typedef logic [7:0] byte_t;
   localparam int BYTE_W = 8;
endpackage

// File: rtl/stream_fifo_if.sv
// stream_fifo_if: StreamBus valid/ready byte handshake
interface stream_fifo_if;
   import stream_pkg::*;
   logic  valid;
   byte_t data;
   logic  ready;
   modport master(output valid, output data, input ready);
   modport slave(input valid, input data, output ready);
endinterface

// File: rtl/stream_fifo_ptr.sv
// fifo_ptr: LW-bit wrap-around pointer with increment enable
module fifo_ptr #(
   parameter int LW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [LW-1:0] ptr
);
   // advance by one per enabled cycle, wrapping naturally at 2^LW
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (inc) ptr <= ptr + LW'(1);
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through byte FIFO with sticky overrun flag
module stream_fifo
   import stream_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   stream_fifo_if.slave        bus_in,
   stream_fifo_if.master       bus_out,
   output logic [LW-1:0]       level,
   output logic                overrun,
   input  logic                overrun_clr
);
   localparam int AW = LW - 1;
   byte_t         mem [DEPTH];
   logic [LW-1:0] wr_ptr, rd_ptr;
   logic          empty, full, push, pop;
   assign empty         = wr_ptr == rd_ptr;
   assign full          = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign level         = wr_ptr - rd_ptr;
   assign bus_in.ready  = !full;
   assign bus_out.valid = !empty;
   assign bus_out.data  = mem[rd_ptr[AW-1:0]];
   assign push          = bus_in.valid && !full;
   assign pop           = bus_out.ready && !empty;
   fifo_ptr #(.LW(LW)) u_wr (.clk(clk), .rst(rst), .inc(push), .ptr(wr_ptr));
   fifo_ptr #(.LW(LW)) u_rd (.clk(clk), .rst(rst), .inc(pop), .ptr(rd_ptr));
   // storage is deliberately not reset; empty pointers hide stale bytes
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= bus_in.data;
   // sticky overrun: a dropped byte beats a same-cycle clear
   always_ff @(posedge clk or posedge rst)
      if (rst) overrun <= 1'b0;
      else if (bus_in.valid && full) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
endmodule
